// File: rtl/ps2_scan_receiver_pkg.sv
// Shared settings for the PS/2 scan receiver: prefix bytes, default tuning values
// and the frame parity helper.
package ps2_scan_receiver_pkg;

  localparam logic [7:0] P_PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] P_PS2_PREFIX_BREAK = 8'hF0;

  localparam int unsigned P_FILTER_LEN_DEFAULT    = 4;
  localparam int unsigned P_TIMEOUT_DEFAULT       = 100000;
  localparam int unsigned P_TIMEOUT_WIDTH_DEFAULT = 17;

  // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan_receiver_line_filter.sv
// ps2_line_filter: 2-FF synchroniser, glitch filter and falling-edge pulse for one
// raw PS/2 line. The filtered level only changes after filter_len identical samples.
module ps2_line_filter #(
  parameter int unsigned P_FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic fall
);

  localparam int unsigned CntW = (P_FILTER_LEN > 1) ? $clog2(P_FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(P_FILTER_LEN - 1);

  logic            meta_q;
  logic            sync_q;
  logic            level_q;
  logic [CntW-1:0] cnt_q;

  // Synchronise the asynchronous line; idle (high) out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
    end
  end

  // Count consecutive samples disagreeing with the filtered level; flip when enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall    <= 1'b0;
    end else if (sync_q == level_q) begin
      cnt_q <= '0;
      fall  <= 1'b0;
    end else if (cnt_q == CntLast) begin
      level_q <= sync_q;
      cnt_q   <= '0;
      fall    <= ~sync_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
      fall  <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver. Deserialises 11-bit frames, checks parity and
// stop bit, absorbs E0/F0 prefixes and emits one scan code per key event.
// Optional inter-edge timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_scan_receiver
  import ps2_scan_receiver_pkg::*;
#(
  parameter int unsigned P_FILTER_LEN = P_FILTER_LEN_DEFAULT
`ifdef PS2_TIMEOUT_EN
  ,
  parameter int unsigned P_TIMEOUT       = P_TIMEOUT_DEFAULT,
  parameter int unsigned P_TIMEOUT_WIDTH = P_TIMEOUT_WIDTH_DEFAULT
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       scan_ext,
  output logic       scan_break,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       par_ok_q;
  logic       ext_q;
  logic       brk_q;
  logic       data_meta_q;
  logic       data_sync_q;
  logic       bit_evt;

`ifdef PS2_TIMEOUT_EN
  localparam logic [P_TIMEOUT_WIDTH-1:0] TmoLast = P_TIMEOUT_WIDTH'(P_TIMEOUT - 1);
  logic [P_TIMEOUT_WIDTH-1:0] tmo_cnt_q;
`endif

  ps2_line_filter #(
    .P_FILTER_LEN(P_FILTER_LEN)
  ) u_clk_filter (
    .clk (clk),
    .rst (rst),
    .line(ps2_clk),
    .fall(bit_evt)
  );

  // Data line only needs synchronising; it is stable around clock falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Frame FSM: advances on bit events, decodes prefixes and drives registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_ok_q   <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      scan_ext   <= 1'b0;
      scan_break <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      if (bit_evt || state_q == StIdle) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + P_TIMEOUT_WIDTH'(1);
      end
`endif
      if (bit_evt) begin
        unique case (state_q)
          StIdle: begin
            // A high "start bit" is a spurious edge; ignore it silently.
            if (!data_sync_q) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shift_q   <= {data_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            par_ok_q <= odd_parity_ok(shift_q, data_sync_q);
            state_q  <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (data_sync_q && par_ok_q) begin
              if (shift_q == P_PS2_PREFIX_EXT) begin
                ext_q <= 1'b1;
              end else if (shift_q == P_PS2_PREFIX_BREAK) begin
                brk_q <= 1'b1;
              end else begin
                scan_code  <= shift_q;
                scan_ext   <= ext_q;
                scan_break <= brk_q;
                scan_valid <= 1'b1;
                ext_q      <= 1'b0;
                brk_q      <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_q     <= 1'b0;
              brk_q     <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      else if (state_q != StIdle && tmo_cnt_q == TmoLast) begin
        // Lost edge: drop the partial frame so the next start bit realigns.
        state_q   <= StIdle;
        ext_q     <= 1'b0;
        brk_q     <= 1'b0;
        frame_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
module tb_ps2_scan_receiver;

  localparam int unsigned TMO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       scan_ext;
  logic       scan_break;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  // Observed event history.
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] mon_code = 8'h00;
  logic       mon_ext = 1'b0;
  logic       mon_brk = 1'b0;

  // Reference model state.
  int         exp_valid = 0;
  int         exp_err = 0;
  logic [7:0] exp_code = 8'h00;
  logic       exp_ext = 1'b0;
  logic       exp_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;

  always #5 clk = ~clk;

`ifdef PS2_TIMEOUT_EN
  ps2_scan_receiver #(
    .P_FILTER_LEN   (4),
    .P_TIMEOUT      (TMO),
    .P_TIMEOUT_WIDTH(17)
  ) dut (
`else
  ps2_scan_receiver #(
    .P_FILTER_LEN(4)
  ) dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .scan_ext  (scan_ext),
    .scan_break(scan_break),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (scan_valid) begin
      valid_cnt++;
      mon_code = scan_code;
      mon_ext  = scan_ext;
      mon_brk  = scan_break;
    end
    if (frame_err) err_cnt++;
    if (scan_valid && frame_err) both_cnt++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Keyboard-side model of what a frame means to the host.
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_valid++;
      exp_code = b;
      exp_ext  = m_ext;
      exp_brk  = m_brk;
      m_ext    = 1'b0;
      m_brk    = 1'b0;
    end
  endtask

  // One bit cell: 10 cycles high with data set, 20 low, 10 high.
  task automatic send_bit(input logic v, input bit glitch);
    @(negedge clk);
    ps2_data = v;
    if (glitch) begin
      wait_n(3);
      ps2_clk = 1'b0;
      wait_n(3);
      ps2_clk = 1'b1;
      wait_n(4);
    end else begin
      wait_n(10);
    end
    ps2_clk = 1'b0;
    wait_n(20);
    ps2_clk = 1'b1;
    wait_n(9);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input logic stop_v,
                            input int glitch_bit);
    logic [10:0] bits;
    bits = {stop_v, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_bit);
    ps2_data = 1'b1;
    wait_n(10);
    model_frame(b, !par_flip && stop_v);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, -1);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid_count"}, valid_cnt, exp_valid);
    chk({tag, ".err_count"}, err_cnt, exp_err);
    chk({tag, ".code"}, {24'h0, mon_code}, {24'h0, exp_code});
    chk({tag, ".ext"}, {31'h0, mon_ext}, {31'h0, exp_ext});
    chk({tag, ".break"}, {31'h0, mon_brk}, {31'h0, exp_brk});
  endtask

  initial begin
    logic [7:0] rb;
    int         r;
    bit         flip;

    wait_n(5);
    chk("reset.code", {24'h0, scan_code}, 32'h0);
    chk("reset.valid", {31'h0, scan_valid}, 32'h0);
    chk("reset.ext", {31'h0, scan_ext}, 32'h0);
    chk("reset.break", {31'h0, scan_break}, 32'h0);
    chk("reset.err", {31'h0, frame_err}, 32'h0);
    rst = 1'b0;
    wait_n(5);

    send_good(8'h1C);
    check_all("make_1c");

    send_good(8'hF0);
    send_good(8'h1C);
    check_all("break_1c");
    send_good(8'h1C);
    check_all("make_after_break");

    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h4A);
    check_all("ext_break_4a");

    send_good(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    check_all("parity_err");
    send_good(8'h16);
    check_all("after_parity_err");

    send_frame(8'h1C, 1'b0, 1'b1, 4);
    check_all("glitch_1c");

    send_frame(8'h2A, 1'b0, 1'b0, -1);
    check_all("stop_err");

    send_good(8'hE0);
    send_good(8'hE0);
    send_good(8'h75);
    check_all("double_e0");

    send_good(8'hF0);
    send_good(8'hE0);
    send_good(8'h6B);
    check_all("f0_then_e0");

`ifdef PS2_TIMEOUT_EN
    send_good(8'hE0);
    for (int i = 0; i < 4; i++) send_bit((i == 0) ? 1'b0 : 1'b1, 1'b0);
    wait_n(TMO + 30);
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    check_all("timeout");
    send_good(8'h16);
    check_all("after_timeout");
`endif

    // Reset mid-frame with a pending break prefix.
    send_good(8'hF0);
    for (int i = 0; i < 4; i++) send_bit((i == 0) ? 1'b0 : 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset.code", {24'h0, scan_code}, 32'h0);
    chk("midreset.valid", {31'h0, scan_valid}, 32'h0);
    chk("midreset.ext", {31'h0, scan_ext}, 32'h0);
    chk("midreset.break", {31'h0, scan_break}, 32'h0);
    chk("midreset.err", {31'h0, frame_err}, 32'h0);
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_n(3);
    rst = 1'b0;
    wait_n(5);
    send_good(8'h16);
    check_all("after_midreset");

    // Random frame stream against the model.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) rb = 8'hE0;
      else if (r < 4) rb = 8'hF0;
      else rb = 8'($urandom);
      flip = ($urandom_range(0, 7) == 0);
      send_frame(rb, flip, 1'b1, -1);
      check_all("random");
    end

    chk("valid_err_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
